ysyx_24110015_mem_arbiter: RTL and testbench
============================================

YSYX_24110015_MEM_ARBITER -- requirements
Module: ysyx_24110015_mem_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, 32, address width; DATA_W, 32, data width; TIMEOUT, 255, maximum cycles waiting for a memory response (1..255).
REQ-002 The design SHALL have one clock; reset is asynchronous and active-low.
REQ-003 Ports SHALL be, in order:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- ifu_req_valid  in  1  fetch request.
- ifu_req_ready  out  1  fetch request accepted this cycle.
- ifu_addr  in  ADDR_W  fetch address.
- ifu_rsp_valid  out  1  one-cycle fetch response pulse.
- ifu_rdata  out  DATA_W  fetched instruction.
- ifu_rsp_err  out  1  fetch error, qualified by ifu_rsp_valid.
- lsu_req_valid  in  1  load/store request.
- lsu_req_ready  out  1  load/store request accepted this cycle.
- lsu_addr  in  ADDR_W  load/store address.
- lsu_wen  in  1  1 = store, 0 = load.
- lsu_wdata  in  DATA_W  store data.
- lsu_wmask  in  DATA_W/8  store byte mask.
- lsu_rsp_valid  out  1  one-cycle load/store response pulse.
- lsu_rdata  out  DATA_W  load data.
- lsu_rsp_err  out  1  load/store error.
- mem_req_valid  out  1  request to shared memory.
- mem_req_ready  in  1  memory accepts request.
- mem_addr, mem_wen, mem_wdata, mem_wmask  out  ADDR_W/1/DATA_W/DATA_W/8  latched request fields.
- mem_rsp_valid  in  1  memory response.
- mem_rdata  in  DATA_W  memory read data.
- mem_rsp_err  in  1  memory error.

Function
REQ-004 The FSM SHALL have three states: IDLE, REQ, WAIT. Exactly one transaction SHALL be outstanding at a time.
REQ-005 In IDLE, the grant SHALL follow these rules:
- Only one valid requester: that requester wins.
- Both valid: the requester not granted last wins (round-robin bit last_grant).
- None valid: no grant.
REQ-006 Ready SHALL be combinational and high only in IDLE, only for the winner; the other ready SHALL stay 0.
REQ-007 When a request is accepted (valid && ready at a rising edge), the following SHALL happen on that edge:
- Owner, address, wen, wdata and wmask are latched. For an IFU request, wen=0, wdata=0 and wmask=0 are latched.
- last_grant is updated.
- The FSM moves to REQ.
REQ-008 In REQ, mem_req_valid SHALL be 1 and the mem_* fields SHALL be held stable; on mem_req_ready=1 the FSM moves to WAIT. In IDLE and WAIT, mem_req_valid SHALL be 0.
REQ-009 Minimum latency SHALL be: accept at edge T; mem_req_valid high in cycle T+1; the owner's rsp_valid pulse in the cycle after the edge where mem_rsp_valid is sampled.
REQ-010 In WAIT, when mem_rsp_valid=1:
- mem_rdata and mem_rsp_err are registered onto the owner's rdata/rsp_err.
- The owner's rsp_valid is 1 for exactly one cycle.
- The FSM returns to IDLE.
- The non-owner's rsp_valid stays 0.
REQ-011 The rdata/rsp_err outputs SHALL hold their last value between responses. Responses SHALL have no backpressure.
REQ-012 The timeout counter SHALL behave as follows:
- It is 8 bits, cleared on entry to WAIT, and increments each WAIT cycle without mem_rsp_valid.
- When it reaches TIMEOUT, the owner gets rsp_valid=1, rsp_err=1 and rdata=0, and the FSM returns to IDLE.
- A mem_rsp_valid arriving in the same cycle the counter reaches TIMEOUT SHALL win over the timeout.
REQ-013 mem_rsp_valid received in IDLE or REQ (stale or spurious) SHALL be ignored, with no output change.
REQ-014 A new request SHALL be acceptable in the same IDLE cycle that a response pulse is being driven.
REQ-015 A requester deasserting valid before acceptance SHALL NOT be granted; request inputs SHALL be ignored outside IDLE.

Reset
REQ-016 While rst=0, the FSM SHALL be IDLE, and all of the following SHALL be 0: last_grant=IFU, counter, latched fields, mem_req_valid, both rsp_valid, both rdata, both rsp_err.
REQ-017 Both ready outputs SHALL be 0 while rst=0.
REQ-018 Reset asserted mid-transaction SHALL abort it with no response pulse; a memory response after reset release SHALL be ignored per REQ-013.

Verification
REQ-019 IFU only: ifu_addr=0x80000000 accepted, mem_req_ready=1 immediately, mem_rsp_valid 3 cycles later with rdata=0x00100073 -> mem_addr=0x80000000 and mem_wen=0; ifu_rsp_valid is a single pulse with ifu_rdata=0x00100073 and err=0; lsu_rsp_valid stays 0.
REQ-020 Contention: both valid continuously from reset release -> grant order LSU, IFU, LSU, IFU; each ready is high for exactly one cycle per grant.
REQ-021 Store: lsu_wen=1, addr=0xa00003f8, wdata=0x41, wmask=0x1; mem_req_ready held 0 for 4 cycles -> the mem_* fields are stable for all 5 REQ cycles and the store completes with lsu_rsp_err=0.
REQ-022 Timeout: TIMEOUT=8, mem_rsp_valid never asserted -> 8 WAIT cycles, then lsu_rsp_valid=1 with err=1 and rdata=0; a later mem_rsp_valid is ignored.
REQ-023 Reset in WAIT: rst pulled to 0 one cycle after mem_req_ready -> all outputs are 0 immediately; a mem_rsp_valid after release produces no rsp pulse.
REQ-024 Back-to-back: an IFU request held valid across a response pulse -> it is accepted in that same IDLE cycle, and the next mem_req_valid follows one cycle later.

Source files
------------

// File: rtl/ysyx_24110015_mem_arbiter.sv
// ysyx_24110015_mem_arbiter
// Shares one memory port between the instruction fetch unit (IFU) and the
// load/store unit (LSU). Only one transaction is in flight at a time. When
// both units request together, round-robin arbitration decides the winner.
// Responses are registered one-cycle pulses. A response timeout completes
// the transaction with an error if the memory never answers.

module ysyx_24110015_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_addr,
  output logic                ifu_rsp_valid,
  output logic [DATA_W-1:0]   ifu_rdata,
  output logic                ifu_rsp_err,
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic                lsu_wen,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wmask,
  output logic                lsu_rsp_valid,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic                lsu_rsp_err,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_wen,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_rsp_valid,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_rsp_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  // The last WAIT cycle before the counter would reach TIMEOUT
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t              r_state;
  state_t              w_next_state;

  logic                r_last_grant;   // 0 = IFU granted last, 1 = LSU
  logic                r_owner;        // 0 = IFU owns the transaction, 1 = LSU
  logic [ADDR_W-1:0]   r_addr;
  logic                r_wen;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W/8-1:0] r_wmask;
  logic [7:0]          r_count;

  logic                r_ifu_rsp_valid;
  logic [DATA_W-1:0]   r_ifu_rdata;
  logic                r_ifu_rsp_err;
  logic                r_lsu_rsp_valid;
  logic [DATA_W-1:0]   r_lsu_rdata;
  logic                r_lsu_rsp_err;

  logic                w_ifu_win;
  logic                w_lsu_win;
  logic                w_ifu_ready;
  logic                w_lsu_ready;
  logic                w_ifu_acc;
  logic                w_lsu_acc;
  logic                w_accept;
  logic                w_mem_req_valid;
  logic                w_rsp_hit;
  logic                w_timeout;
  logic                w_finish;
  logic [DATA_W-1:0]   w_rsp_data;
  logic                w_rsp_err;

  // A lone requester always wins; with two requesters, the one not granted last wins.
  assign w_ifu_win = ifu_req_valid & (~lsu_req_valid | r_last_grant);
  assign w_lsu_win = lsu_req_valid & (~ifu_req_valid | ~r_last_grant);

  // Ready is forced low while reset is held, even though the state is already IDLE.
  assign ifu_req_ready = w_ifu_ready & rst;
  assign lsu_req_ready = w_lsu_ready & rst;

  assign w_ifu_acc = ifu_req_valid & ifu_req_ready;
  assign w_lsu_acc = lsu_req_valid & lsu_req_ready;
  assign w_accept  = w_ifu_acc | w_lsu_acc;

  // A real response in the final counted cycle takes priority over the timeout.
  assign w_rsp_hit  = (r_state == WAIT) & mem_rsp_valid;
  assign w_timeout  = (r_state == WAIT) & ~mem_rsp_valid & (r_count == TO_LAST);
  assign w_finish   = w_rsp_hit | w_timeout;
  assign w_rsp_data = w_rsp_hit ? mem_rdata : '0;
  assign w_rsp_err  = w_rsp_hit ? mem_rsp_err : 1'b1;

  assign mem_req_valid = w_mem_req_valid;
  assign mem_addr      = r_addr;
  assign mem_wen       = r_wen;
  assign mem_wdata     = r_wdata;
  assign mem_wmask     = r_wmask;

  assign ifu_rsp_valid = r_ifu_rsp_valid;
  assign ifu_rdata     = r_ifu_rdata;
  assign ifu_rsp_err   = r_ifu_rsp_err;
  assign lsu_rsp_valid = r_lsu_rsp_valid;
  assign lsu_rdata     = r_lsu_rdata;
  assign lsu_rsp_err   = r_lsu_rsp_err;

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic, grant readies and the memory request strobe.
  always_comb begin
    w_next_state    = r_state;
    w_ifu_ready     = 1'b0;
    w_lsu_ready     = 1'b0;
    w_mem_req_valid = 1'b0;
    case (r_state)
      IDLE: begin
        w_ifu_ready = w_ifu_win;
        w_lsu_ready = w_lsu_win;
        if (w_accept) begin
          w_next_state = REQ;
        end
      end
      REQ: begin
        w_mem_req_valid = 1'b1;
        if (mem_req_ready) begin
          w_next_state = WAIT;
        end
      end
      WAIT: begin
        if (w_finish) begin
          w_next_state = IDLE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Latch the winner's request fields and the round-robin bit on acceptance.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last_grant <= 1'b0;
      r_owner      <= 1'b0;
      r_addr       <= '0;
      r_wen        <= 1'b0;
      r_wdata      <= '0;
      r_wmask      <= '0;
    end else if (w_accept) begin
      r_last_grant <= w_lsu_acc;
      r_owner      <= w_lsu_acc;
      r_addr       <= w_lsu_acc ? lsu_addr : ifu_addr;
      r_wen        <= w_lsu_acc & lsu_wen;
      r_wdata      <= w_lsu_acc ? lsu_wdata : '0;
      r_wmask      <= w_lsu_acc ? lsu_wmask : '0;
    end
  end

  // Count WAIT cycles without a response, starting from zero on entry to WAIT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if ((r_state == REQ) && mem_req_ready) begin
      r_count <= '0;
    end else if ((r_state == WAIT) && !mem_rsp_valid) begin
      r_count <= r_count + 8'd1;
    end
  end

  // Register the response to its owner as a single-cycle pulse; data holds in between.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ifu_rsp_valid <= 1'b0;
      r_ifu_rdata     <= '0;
      r_ifu_rsp_err   <= 1'b0;
      r_lsu_rsp_valid <= 1'b0;
      r_lsu_rdata     <= '0;
      r_lsu_rsp_err   <= 1'b0;
    end else begin
      r_ifu_rsp_valid <= w_finish & ~r_owner;
      r_lsu_rsp_valid <= w_finish & r_owner;
      if (w_finish && !r_owner) begin
        r_ifu_rdata   <= w_rsp_data;
        r_ifu_rsp_err <= w_rsp_err;
      end
      if (w_finish && r_owner) begin
        r_lsu_rdata   <= w_rsp_data;
        r_lsu_rsp_err <= w_rsp_err;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_24110015_mem_arbiter.sv
// tb_ysyx_24110015_mem_arbiter
// Self-checking bench for the IFU/LSU memory arbiter. A table of directed
// transactions, then hand-written corner sequences, then random transactions
// whose expected grant, response data and timing come from a transaction-level
// reference model.

module tb_ysyx_24110015_mem_arbiter;

  localparam int TIMEOUT = 8;

  typedef struct {
    logic        ifuV;
    logic        lsuV;
    logic [31:0] ifuAddr;
    logic [31:0] lsuAddr;
    logic        lsuWen;
    logic [31:0] lsuWdata;
    logic [3:0]  lsuWmask;
    int          reqDelay;   // cycles mem_req_ready is held low in REQ
    int          rspDelay;   // WAIT cycle index of mem_rsp_valid; >= TIMEOUT means never
    logic [31:0] memRdata;
    logic        memErr;
    logic        expLsu;     // expected owner: 1 = LSU, 0 = IFU
    logic [31:0] expRdata;
    logic        expErr;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid, ifu_rsp_err;
  logic [31:0] ifu_addr, ifu_rdata;
  logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_rsp_valid, lsu_rsp_err;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [3:0]  lsu_wmask;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_rsp_valid, mem_rsp_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;

  int          totalChecks = 0;
  int          passChecks  = 0;
  logic        tbLast;
  logic [31:0] holdIfuRdata, holdLsuRdata;
  logic        holdIfuErr, holdLsuErr;
  txn_t        vecs[6];

  ysyx_24110015_mem_arbiter #(
    .ADDR_W (32),
    .DATA_W (32),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ifu_req_valid(ifu_req_valid),
    .ifu_req_ready(ifu_req_ready),
    .ifu_addr     (ifu_addr),
    .ifu_rsp_valid(ifu_rsp_valid),
    .ifu_rdata    (ifu_rdata),
    .ifu_rsp_err  (ifu_rsp_err),
    .lsu_req_valid(lsu_req_valid),
    .lsu_req_ready(lsu_req_ready),
    .lsu_addr     (lsu_addr),
    .lsu_wen      (lsu_wen),
    .lsu_wdata    (lsu_wdata),
    .lsu_wmask    (lsu_wmask),
    .lsu_rsp_valid(lsu_rsp_valid),
    .lsu_rdata    (lsu_rdata),
    .lsu_rsp_err  (lsu_rsp_err),
    .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready),
    .mem_addr     (mem_addr),
    .mem_wen      (mem_wen),
    .mem_wdata    (mem_wdata),
    .mem_wmask    (mem_wmask),
    .mem_rsp_valid(mem_rsp_valid),
    .mem_rdata    (mem_rdata),
    .mem_rsp_err  (mem_rsp_err)
  );

  // Free-running 10-time-unit clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    totalChecks++;
    if (actual === expected) begin
      passChecks++;
    end else begin
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic checkBit(input string name, input logic actual, input logic expected);
    checkOutput(name, {31'b0, actual}, {31'b0, expected});
  endtask

  task automatic checkResetOutputs(input string tag);
    checkBit({tag, "_mem_req_valid"}, mem_req_valid, 1'b0);
    checkBit({tag, "_ifu_ready"}, ifu_req_ready, 1'b0);
    checkBit({tag, "_lsu_ready"}, lsu_req_ready, 1'b0);
    checkBit({tag, "_ifu_rsp_valid"}, ifu_rsp_valid, 1'b0);
    checkBit({tag, "_lsu_rsp_valid"}, lsu_rsp_valid, 1'b0);
    checkOutput({tag, "_ifu_rdata"}, ifu_rdata, 32'h0);
    checkOutput({tag, "_lsu_rdata"}, lsu_rdata, 32'h0);
    checkBit({tag, "_ifu_err"}, ifu_rsp_err, 1'b0);
    checkBit({tag, "_lsu_err"}, lsu_rsp_err, 1'b0);
    checkOutput({tag, "_mem_addr"}, mem_addr, 32'h0);
    checkBit({tag, "_mem_wen"}, mem_wen, 1'b0);
    checkOutput({tag, "_mem_wdata"}, mem_wdata, 32'h0);
    checkOutput({tag, "_mem_wmask"}, 32'(mem_wmask), 32'h0);
  endtask

  task automatic checkHold(input string tag);
    checkOutput({tag, "_ifu_rdata"}, ifu_rdata, holdIfuRdata);
    checkBit({tag, "_ifu_err"}, ifu_rsp_err, holdIfuErr);
    checkOutput({tag, "_lsu_rdata"}, lsu_rdata, holdLsuRdata);
    checkBit({tag, "_lsu_err"}, lsu_rsp_err, holdLsuErr);
  endtask

  task automatic resetModel();
    tbLast       = 1'b0;
    holdIfuRdata = '0;
    holdLsuRdata = '0;
    holdIfuErr   = 1'b0;
    holdLsuErr   = 1'b0;
  endtask

  // Hold reset with both requesters valid; readies must stay low throughout.
  task automatic doReset(input logic keepValids);
    rst           = 1'b0;
    ifu_req_valid = 1'b1;
    lsu_req_valid = 1'b1;
    ifu_addr      = 32'h0;
    lsu_addr      = 32'h0;
    lsu_wen       = 1'b0;
    lsu_wdata     = 32'h0;
    lsu_wmask     = 4'h0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rdata     = 32'h0;
    mem_rsp_err   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkResetOutputs("reset");
    @(posedge clk);
    #1;
    if (!keepValids) begin
      ifu_req_valid = 1'b0;
      lsu_req_valid = 1'b0;
    end
    rst = 1'b1;
    resetModel();
  endtask

  // Reference model: round-robin owner and the response/timeout rule.
  function automatic txn_t makeRandomTxn();
    txn_t t;
    int   sel;
    sel        = $urandom_range(1, 3);
    t.ifuV     = sel[0];
    t.lsuV     = sel[1];
    t.ifuAddr  = $urandom;
    t.lsuAddr  = $urandom;
    t.lsuWen   = 1'($urandom);
    t.lsuWdata = $urandom;
    t.lsuWmask = 4'($urandom);
    t.reqDelay = $urandom_range(0, 3);
    t.rspDelay = $urandom_range(0, TIMEOUT + 1);
    t.memRdata = $urandom;
    t.memErr   = 1'($urandom);
    if (t.ifuV && t.lsuV) begin
      t.expLsu = ~tbLast;
    end else begin
      t.expLsu = t.lsuV;
    end
    if (t.rspDelay < TIMEOUT) begin
      t.expRdata = t.memRdata;
      t.expErr   = t.memErr;
    end else begin
      t.expRdata = 32'h0;
      t.expErr   = 1'b1;
    end
    return t;
  endfunction

  // Drive one full transaction from IDLE and check every cycle of it.
  task automatic applyStimulus(input txn_t t);
    logic [31:0] expAddr, expWdata;
    logic        expWen;
    logic [3:0]  expWmask;
    int          nWait;
    expAddr  = t.expLsu ? t.lsuAddr : t.ifuAddr;
    expWen   = t.expLsu ? t.lsuWen : 1'b0;
    expWdata = t.expLsu ? t.lsuWdata : 32'h0;
    expWmask = t.expLsu ? t.lsuWmask : 4'h0;
    nWait    = (t.rspDelay < TIMEOUT) ? t.rspDelay + 1 : TIMEOUT;

    ifu_req_valid = t.ifuV;
    lsu_req_valid = t.lsuV;
    ifu_addr      = t.ifuAddr;
    lsu_addr      = t.lsuAddr;
    lsu_wen       = t.lsuWen;
    lsu_wdata     = t.lsuWdata;
    lsu_wmask     = t.lsuWmask;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    @(negedge clk);
    checkBit("idle_ifu_ready", ifu_req_ready, ~t.expLsu);
    checkBit("idle_lsu_ready", lsu_req_ready, t.expLsu);
    checkBit("idle_mem_req_valid", mem_req_valid, 1'b0);
    @(posedge clk);
    #1;

    for (int c = 0; c <= t.reqDelay; c++) begin
      mem_req_ready = (c == t.reqDelay);
      mem_rsp_valid = 1'($urandom);
      mem_rdata     = $urandom;
      mem_rsp_err   = 1'($urandom);
      ifu_req_valid = 1'($urandom);
      lsu_req_valid = 1'($urandom);
      ifu_addr      = $urandom;
      lsu_addr      = $urandom;
      lsu_wen       = 1'($urandom);
      lsu_wdata     = $urandom;
      lsu_wmask     = 4'($urandom);
      @(negedge clk);
      checkBit("req_mem_req_valid", mem_req_valid, 1'b1);
      checkOutput("req_mem_addr", mem_addr, expAddr);
      checkBit("req_mem_wen", mem_wen, expWen);
      checkOutput("req_mem_wdata", mem_wdata, expWdata);
      checkOutput("req_mem_wmask", 32'(mem_wmask), 32'(expWmask));
      checkBit("req_ifu_ready", ifu_req_ready, 1'b0);
      checkBit("req_lsu_ready", lsu_req_ready, 1'b0);
      checkBit("req_ifu_rsp_valid", ifu_rsp_valid, 1'b0);
      checkBit("req_lsu_rsp_valid", lsu_rsp_valid, 1'b0);
      checkHold("req");
      @(posedge clk);
      #1;
    end

    for (int c = 0; c < nWait; c++) begin
      mem_req_ready = 1'($urandom);
      mem_rsp_valid = (c == t.rspDelay);
      mem_rdata     = (c == t.rspDelay) ? t.memRdata : $urandom;
      mem_rsp_err   = (c == t.rspDelay) ? t.memErr : 1'($urandom);
      if (c == nWait - 1) begin
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
      end else begin
        ifu_req_valid = 1'($urandom);
        lsu_req_valid = 1'($urandom);
      end
      @(negedge clk);
      checkBit("wait_mem_req_valid", mem_req_valid, 1'b0);
      checkBit("wait_ifu_ready", ifu_req_ready, 1'b0);
      checkBit("wait_lsu_ready", lsu_req_ready, 1'b0);
      checkBit("wait_ifu_rsp_valid", ifu_rsp_valid, 1'b0);
      checkBit("wait_lsu_rsp_valid", lsu_rsp_valid, 1'b0);
      @(posedge clk);
      #1;
    end

    mem_rsp_valid = 1'b0;
    mem_req_ready = 1'b0;
    if (t.expLsu) begin
      holdLsuRdata = t.expRdata;
      holdLsuErr   = t.expErr;
    end else begin
      holdIfuRdata = t.expRdata;
      holdIfuErr   = t.expErr;
    end
    @(negedge clk);
    checkBit("pulse_ifu_rsp_valid", ifu_rsp_valid, ~t.expLsu);
    checkBit("pulse_lsu_rsp_valid", lsu_rsp_valid, t.expLsu);
    checkBit("pulse_mem_req_valid", mem_req_valid, 1'b0);
    checkHold("pulse");
    @(posedge clk);
    #1;
    @(negedge clk);
    checkBit("after_ifu_rsp_valid", ifu_rsp_valid, 1'b0);
    checkBit("after_lsu_rsp_valid", lsu_rsp_valid, 1'b0);
    checkHold("after");
    @(posedge clk);
    #1;
    tbLast = t.expLsu;
  endtask

  initial begin
    // {ifuV, lsuV, ifuAddr, lsuAddr, lsuWen, lsuWdata, lsuWmask, reqDelay, rspDelay,
    //  memRdata, memErr, expLsu, expRdata, expErr}
    vecs[0] = '{1'b1, 1'b0, 32'h80000000, 32'h0, 1'b0, 32'h0, 4'h0, 0, 2,
                32'h00100073, 1'b0, 1'b0, 32'h00100073, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 32'h0, 32'ha00003f8, 1'b1, 32'h00000041, 4'h1, 4, 0,
                32'h0, 1'b0, 1'b1, 32'h0, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 32'h80000004, 32'h12345678, 1'b1, 32'ha5a5a5a5, 4'hf, 1, 1,
                32'hdeadbeef, 1'b1, 1'b0, 32'hdeadbeef, 1'b1};
    vecs[3] = '{1'b1, 1'b1, 32'h80000008, 32'h00000010, 1'b0, 32'hffffffff, 4'hf, 0, TIMEOUT - 1,
                32'hcafef00d, 1'b0, 1'b1, 32'hcafef00d, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 32'h0, 32'h00000020, 1'b0, 32'h0, 4'h0, 0, 50,
                32'h11111111, 1'b0, 1'b1, 32'h0, 1'b1};
    vecs[5] = '{1'b1, 1'b0, 32'h8000000c, 32'h0, 1'b0, 32'h0, 4'h0, 2, 50,
                32'h22222222, 1'b0, 1'b0, 32'h0, 1'b1};

    doReset(1'b0);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i]);
    end

    // A response arriving in IDLE after a timeout must change nothing.
    for (int c = 0; c < 2; c++) begin
      mem_rsp_valid = 1'b1;
      mem_rdata     = 32'h5a5a0000 + c;
      mem_rsp_err   = 1'b0;
      @(negedge clk);
      checkBit("stale_ifu_rsp_valid", ifu_rsp_valid, 1'b0);
      checkBit("stale_lsu_rsp_valid", lsu_rsp_valid, 1'b0);
      checkBit("stale_mem_req_valid", mem_req_valid, 1'b0);
      checkHold("stale");
      @(posedge clk);
      #1;
    end
    mem_rsp_valid = 1'b0;

    // Back-to-back: IFU valid held across its response pulse is accepted in that cycle.
    ifu_req_valid = 1'b1;
    ifu_addr      = 32'h80001000;
    mem_req_ready = 1'b1;
    @(negedge clk);
    checkBit("b2b_first_ready", ifu_req_ready, 1'b1);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("b2b_first_addr", mem_addr, 32'h80001000);
    @(posedge clk);
    #1;
    mem_rsp_valid = 1'b1;
    mem_rdata     = 32'h0badc0de;
    mem_rsp_err   = 1'b0;
    @(posedge clk);
    #1;
    mem_rsp_valid = 1'b0;
    ifu_addr      = 32'h80002000;
    @(negedge clk);
    checkBit("b2b_pulse", ifu_rsp_valid, 1'b1);
    checkOutput("b2b_pulse_rdata", ifu_rdata, 32'h0badc0de);
    checkBit("b2b_ready_in_pulse", ifu_req_ready, 1'b1);
    checkBit("b2b_pulse_mem_req_valid", mem_req_valid, 1'b0);
    @(posedge clk);
    #1;
    ifu_req_valid = 1'b0;
    @(negedge clk);
    checkBit("b2b_second_mem_req_valid", mem_req_valid, 1'b1);
    checkOutput("b2b_second_addr", mem_addr, 32'h80002000);
    checkBit("b2b_no_double_pulse", ifu_rsp_valid, 1'b0);
    @(posedge clk);
    #1;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rdata     = 32'h13579bdf;
    @(posedge clk);
    #1;
    mem_rsp_valid = 1'b0;
    @(negedge clk);
    checkBit("b2b_second_pulse", ifu_rsp_valid, 1'b1);
    checkOutput("b2b_second_rdata", ifu_rdata, 32'h13579bdf);
    @(posedge clk);
    #1;

    // Reset one cycle after mem_req_ready aborts the transaction silently.
    lsu_req_valid = 1'b1;
    lsu_addr      = 32'ha0000100;
    lsu_wen       = 1'b1;
    lsu_wdata     = 32'h77;
    lsu_wmask     = 4'h3;
    mem_req_ready = 1'b1;
    @(posedge clk);
    #1;
    lsu_req_valid = 1'b0;
    @(posedge clk);
    #1;
    mem_req_ready = 1'b0;
    rst           = 1'b0;
    #1;
    checkResetOutputs("rst_wait");
    @(posedge clk);
    #1;
    rst = 1'b1;
    resetModel();
    for (int c = 0; c < 3; c++) begin
      mem_rsp_valid = 1'b1;
      mem_rdata     = 32'hfeedface;
      mem_rsp_err   = 1'b1;
      @(negedge clk);
      checkBit("postrst_ifu_rsp_valid", ifu_rsp_valid, 1'b0);
      checkBit("postrst_lsu_rsp_valid", lsu_rsp_valid, 1'b0);
      checkHold("postrst");
      @(posedge clk);
      #1;
    end
    mem_rsp_valid = 1'b0;

    // Contention from reset release: grants alternate LSU, IFU, LSU, IFU every 3 cycles.
    doReset(1'b1);
    mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b1;
    mem_rdata     = 32'h0;
    mem_rsp_err   = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      checkBit("rr_ifu_ready", ifu_req_ready, (i % 3 == 0) && ((i / 3) % 2 == 1));
      checkBit("rr_lsu_ready", lsu_req_ready, (i % 3 == 0) && ((i / 3) % 2 == 0));
      @(posedge clk);
      #1;
    end
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Random transactions against the reference model.
    doReset(1'b0);
    for (int i = 0; i < 40; i++) begin
      applyStimulus(makeRandomTxn());
    end

    $display("%0d/%0d checks passed", passChecks, totalChecks);
    $finish;
  end

endmodule
